avalon_port_arbiter: RTL and testbench

Parametrised Avalon-MM master arbiter that multiplexes `CHANNELS` independent CPU-side memory ports (e.g. instruction fetch and data load/store) onto one Avalon memory-mapped master bus. Each client gets a request/done handshake and a combinational stall signal usable as a clock enable for the CPU core. Sits between `mips_cpu` and the memory/cache subsystem, replacing the fixed two-port bridge with an N-channel arbiter that has explicit transfer sequencing.

---
 rtl/avalon_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_avalon_port_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/avalon_port_arbiter.sv
// avalon_port_arbiter
//   Multiplexes CHANNELS CPU-side memory ports onto one Avalon-MM master.
//   Each transfer runs IDLE -> BUS -> RESP, so the best case is one
//   transfer every 3 cycles.
//   Every Avalon output is registered.
//   ch_stall can be used directly as an inverted clock enable for the core.
//
// Build option:
//   ARB_ROUND_ROBIN_EN  when defined, round-robin grant. The search starts
//                       at a rotating pointer. When undefined, fixed
//                       priority is used and index 0 wins.
//
// Ports:
//   clk, reset     single clock, synchronous active-high reset
//   ch_req         per-channel request, held until the matching ch_done
//   ch_write       per-channel direction (1 = write)
//   ch_address     packed per-channel address   [i*ADDR_W +: ADDR_W]
//   ch_writedata   packed per-channel write data [i*DATA_W +: DATA_W]
//   ch_byteenable  packed per-channel byte enables
//   ch_readdata    data of the most recent completed read (shared)
//   ch_done        one-cycle completion pulse, one-hot or zero
//   ch_stall       ch_req & ~ch_done, combinational
//   address, read, write, writedata, byteenable   Avalon master outputs
//   waitrequest, readdata                         Avalon slave inputs
module avalon_port_arbiter #(
   parameter int CHANNELS = 2,
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [CHANNELS-1:0]            ch_req,
   input  logic [CHANNELS-1:0]            ch_write,
   input  logic [CHANNELS*ADDR_W-1:0]     ch_address,
   input  logic [CHANNELS*DATA_W-1:0]     ch_writedata,
   input  logic [CHANNELS*(DATA_W/8)-1:0] ch_byteenable,
   output logic [DATA_W-1:0]              ch_readdata,
   output logic [CHANNELS-1:0]            ch_done,
   output logic [CHANNELS-1:0]            ch_stall,
   output logic [ADDR_W-1:0]              address,
   output logic                           read,
   output logic                           write,
   input  logic                           waitrequest,
   output logic [DATA_W-1:0]              writedata,
   output logic [DATA_W/8-1:0]            byteenable,
   input  logic [DATA_W-1:0]              readdata
);

   localparam int BE_W = DATA_W / 8;
   localparam int G_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t          state, state_nxt;
   logic [G_W-1:0]  gnt;      // combinational winner, valid in IDLE
   logic [G_W-1:0]  gnt_q;    // channel owning the current transfer
   logic            any_req;
   logic            launch;
   logic            finish;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [BE_W-1:0]   sel_be;
   logic              sel_wr;

   assign any_req  = |ch_req;
   assign launch   = (state == IDLE) && any_req;
   assign finish   = (state == BUS) && !waitrequest;
   assign ch_stall = ch_req & ~ch_done;

   // ---------------- grant selection ----------------
`ifdef ARB_ROUND_ROBIN_EN
   logic [G_W-1:0] ptr;
   logic [G_W-1:0] gnt_hi, gnt_lo;
   logic           hit_hi;

   // Lowest requester at or above ptr wins.
   // If there is none, the search wraps to the lowest requester overall.
   always_comb begin
      gnt_hi = '0;
      gnt_lo = '0;
      hit_hi = 1'b0;
      for (int k = CHANNELS - 1; k >= 0; k--) begin
         if (ch_req[k]) gnt_lo = G_W'(k);
         if (ch_req[k] && (k >= int'(ptr))) begin
            gnt_hi = G_W'(k);
            hit_hi = 1'b1;
         end
      end
      gnt = hit_hi ? gnt_hi : gnt_lo;
   end

   always_ff @(posedge clk) begin
      if (reset)
         ptr <= '0;
      else if (launch)
         ptr <= (int'(gnt) == CHANNELS - 1) ? '0 : gnt + G_W'(1);
   end
`else
   always_comb begin
      gnt = '0;
      for (int k = CHANNELS - 1; k >= 0; k--)
         if (ch_req[k]) gnt = G_W'(k);
   end
`endif

   // Fields of the winning channel
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_be    = '0;
      sel_wr    = 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (gnt == G_W'(k)) begin
            sel_addr  = ch_address[k*ADDR_W +: ADDR_W];
            sel_wdata = ch_writedata[k*DATA_W +: DATA_W];
            sel_be    = ch_byteenable[k*BE_W +: BE_W];
            sel_wr    = ch_write[k];
         end
      end
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = BUS;
         BUS:     if (!waitrequest) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- datapath ----------------
   // Bus fields load only at launch, so they hold their last value outside BUS.
   always_ff @(posedge clk) begin
      if (reset) begin
         address     <= '0;
         writedata   <= '0;
         byteenable  <= '0;
         read        <= 1'b0;
         write       <= 1'b0;
         ch_done     <= '0;
         ch_readdata <= '0;
         gnt_q       <= '0;
      end else begin
         ch_done <= '0;
         if (launch) begin
            gnt_q      <= gnt;
            address    <= sel_addr;
            writedata  <= sel_wdata;
            byteenable <= sel_be;
            write      <= sel_wr;
            read       <= ~sel_wr;
         end
         if (finish) begin
            read  <= 1'b0;
            write <= 1'b0;
            if (read) ch_readdata <= readdata;
            ch_done[gnt_q] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_avalon_port_arbiter.sv
module tb_avalon_port_arbiter;

   localparam int CH = 2;
   localparam int AW = 32;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            reset;
   logic [CH-1:0]   ch_req, ch_write;
   logic [CH*AW-1:0] ch_address;
   logic [CH*DW-1:0] ch_writedata;
   logic [CH*4-1:0]  ch_byteenable;
   logic [DW-1:0]   ch_readdata;
   logic [CH-1:0]   ch_done, ch_stall;
   logic [AW-1:0]   address;
   logic            read, write, waitrequest;
   logic [DW-1:0]   writedata, readdata;
   logic [3:0]      byteenable;

   int n_cmp = 0;
   int n_err = 0;

   avalon_port_arbiter #(.CHANNELS(CH), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset),
      .ch_req(ch_req), .ch_write(ch_write), .ch_address(ch_address),
      .ch_writedata(ch_writedata), .ch_byteenable(ch_byteenable),
      .ch_readdata(ch_readdata), .ch_done(ch_done), .ch_stall(ch_stall),
      .address(address), .read(read), .write(write),
      .waitrequest(waitrequest), .writedata(writedata),
      .byteenable(byteenable), .readdata(readdata)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, expected summary before %0t", $time);
      $fatal(1, "watchdog");
   end

   typedef struct {
      int          ch;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          waits;
      logic [31:0] rdata;   // slave read data on the accepting cycle
      logic [31:0] exp_rd;  // ch_readdata expected after completion
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts from an IDLE cycle (just after a rising edge) and ends in the next IDLE cycle.
   task automatic run_vec(input vec_t v);
      logic [CH-1:0] onehot;
      onehot = '0;
      onehot[v.ch] = 1'b1;
      ch_req = onehot;
      ch_write[v.ch] = v.wr;
      ch_address[v.ch*AW +: AW] = v.addr;
      ch_writedata[v.ch*DW +: DW] = v.wdata;
      ch_byteenable[v.ch*4 +: 4] = v.be;
      waitrequest = 1'b0;
      @(negedge clk);
      check("idle_strobes", {read, write}, 2'b00);
      check("idle_stall", ch_stall, onehot);
      tick();
      for (int w = 0; w <= v.waits; w++) begin
         waitrequest = (w < v.waits);
         readdata = (w < v.waits) ? 32'h0BAD_0BAD : v.rdata;
         @(negedge clk);
         check("bus_read", read, !v.wr);
         check("bus_write", write, v.wr);
         check("bus_addr", address, v.addr);
         check("bus_wdata", writedata, v.wdata);
         check("bus_be", byteenable, v.be);
         check("bus_done", ch_done, 0);
         check("bus_stall", ch_stall, onehot);
         tick();
      end
      waitrequest = 1'b0;
      readdata = 32'h0;
      @(negedge clk);
      check("resp_done", ch_done, onehot);
      check("resp_rdata", ch_readdata, v.exp_rd);
      check("resp_strobes", {read, write}, 2'b00);
      check("resp_addr_held", address, v.addr);
      check("resp_stall", ch_stall, 0);
      tick();
      ch_req = '0;
      @(negedge clk);
      check("post_done", ch_done, 0);
      check("post_strobes", {read, write}, 2'b00);
      tick();
   endtask

   initial begin
      logic [CH-1:0] exp_done;
      vec_t rv;
      int ndone;

      vecs[0] = '{1, 1'b0, 32'h0000_0040, 32'h0,         4'b1111, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      vecs[1] = '{0, 1'b1, 32'h0000_0100, 32'h1234_5678, 4'b0011, 3, 32'h0,         32'hDEAD_BEEF};
      vecs[2] = '{0, 1'b0, 32'h0000_0200, 32'h0,         4'b1111, 1, 32'hCAFE_F00D, 32'hCAFE_F00D};
      vecs[3] = '{1, 1'b1, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 4'b1100, 0, 32'h0,         32'hCAFE_F00D};
      vecs[4] = '{1, 1'b0, 32'h0000_0008, 32'h0,         4'b0001, 2, 32'h0000_0001, 32'h0000_0001};

      reset = 1'b1;
      ch_req = '0; ch_write = '0; ch_address = '0; ch_writedata = '0; ch_byteenable = '0;
      waitrequest = 1'b0; readdata = '0;
      tick(); tick();
      reset = 1'b0;
      @(negedge clk);
      check("rst_address", address, 0);
      check("rst_wdata", writedata, 0);
      check("rst_be", byteenable, 0);
      check("rst_strobes", {read, write}, 2'b00);
      check("rst_done", ch_done, 0);
      check("rst_rdata", ch_readdata, 0);
      tick();

      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // Contention: both channels request continuously, zero-wait slave.
      ch_req = 2'b11; ch_write = 2'b00;
      ch_address = {32'h0000_2000, 32'h0000_1000};
      waitrequest = 1'b0; readdata = 32'h5555_AAAA;
      for (int c = 0; c < 12; c++) begin
         exp_done = '0;
         if (c % 3 == 2) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_done = ((c / 3) % 2 == 1) ? 2'b10 : 2'b01;
`else
            exp_done = 2'b01;
`endif
         end
         @(negedge clk);
         check("cont_done", ch_done, exp_done);
         check("cont_stall", ch_stall, 2'b11 & ~exp_done);
         tick();
      end
      ch_req = '0;
      tick();

      // Reset while in BUS with the slave stalling.
      ch_req = 2'b01; ch_write = 2'b00; ch_address[31:0] = 32'h0000_0300;
      waitrequest = 1'b1;
      tick();
      @(negedge clk);
      check("rstbus_read_before", read, 1'b1);
      reset = 1'b1;
      ch_req = '0;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("rstbus_strobes", {read, write}, 2'b00);
      check("rstbus_done", ch_done, 0);
      check("rstbus_address", address, 0);
      check("rstbus_rdata", ch_readdata, 0);
      tick();
      rv = '{0, 1'b0, 32'h0000_0304, 32'h0, 4'b1111, 0, 32'h1122_3344, 32'h1122_3344};
      run_vec(rv);

      // Request withdrawn while in BUS: transfer still completes exactly once.
      ch_req = 2'b10; ch_write = 2'b10;
      ch_address[63:32] = 32'h0000_0500; ch_writedata[63:32] = 32'h0000_0077;
      ch_byteenable[7:4] = 4'b1111;
      waitrequest = 1'b1;
      tick();
      ch_req = '0;
      ndone = 0;
      for (int c = 1; c <= 6; c++) begin
         waitrequest = (c < 3);
         @(negedge clk);
         if (ch_done != 0) ndone++;
         check("drop_done", ch_done, (c == 4) ? 2'b10 : 2'b00);
         check("drop_write", write, (c <= 3));
         check("drop_read", read, 1'b0);
         tick();
      end
      check("drop_ndone", ndone, 1);
      check("drop_rdata_kept", ch_readdata, 32'h1122_3344);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
